pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//   Sequences bring-up of the system PLL. Holds the PLL in reset after power-up, waits for lock with
//   timeout/retry, then requires lock to stay high for a debounce window before releasing system reset.
//   Re-sequences on lock loss or on a software request. Sits beside the PLL wrapper on the free-running refclk.
// PARAMETERS
//   RST_HOLD_CYCLES     16     cycles pll_rst is held high on each sequence start (>=1)
//   LOCK_TIMEOUT_CYCLES 50000  max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//   LOCK_STABLE_CYCLES  1024   consecutive synced-lock-high cycles required before release (>=1)
//   MAX_RETRIES         3      timeouts tolerated before FAULT (only with PLL_SEQ_FAULT_EN)
// PORTS
//   refclk        in   1  reference clock; sole clock of this block
//   rst           in   1  synchronous, active-high reset
//   locked        in   1  PLL lock indicator, asynchronous to refclk
//   force_relock  in   1  single-cycle request to re-run the full sequence
//   pll_rst       out  1  reset to the PLL
//   sys_rst       out  1  system reset, high until lock is stable
//   ready         out  1  high only in RUN
//   lock_lost     out  1  one-cycle pulse when lock drops in RUN
//   retry_count   out  8  timeouts since last RUN entry, saturates at 255
//   fault         out  1  sticky sequencing failure (0 without PLL_SEQ_FAULT_EN)
// BEHAVIOUR
//   - All outputs registered. Reset values: pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_count=0,
//     fault=0, state=HOLD, counters=0. rst asserted in any state restores these at the next edge.
//   - locked passes through a 2-flop synchronizer -> locked_s (2-cycle latency); only locked_s is used.
//   - HOLD: pll_rst=1; count RST_HOLD_CYCLES cycles, then -> WAIT_LOCK (pll_rst=0 from the first
//     WAIT_LOCK cycle).
//   - WAIT_LOCK: pll_rst=0. A locked_s=1 sample -> STABLE with stable count=1. After LOCK_TIMEOUT_CYCLES
//     cycles without lock -> retry_count+1 (saturating), -> HOLD.
//   - STABLE: locked_s=1 increments the stable count; on reaching LOCK_STABLE_CYCLES -> RUN.
//     locked_s=0 -> WAIT_LOCK with timeout counter reset (debounce restart, not a retry).
//   - RUN: sys_rst=0, ready=1, retry_count cleared on entry. sys_rst falls exactly LOCK_STABLE_CYCLES+2
//     edges after the first edge sampling locked=1, provided lock stays high.
//   - RUN exit: locked_s=0 -> lock_lost pulses one cycle, -> HOLD; force_relock=1 -> HOLD with no pulse.
//     Both in the same cycle: single re-sequence, lock_lost pulses. sys_rst=1 and ready=0 on the HOLD
//     entry edge.
//   - force_relock in HOLD/WAIT_LOCK/STABLE: restart at HOLD with counters cleared; retry_count unchanged.
//   - Counter widths are $clog2(param+1); no wrap is possible because every count compares against its limit.
// CONFIGURATION
//   PLL_SEQ_FAULT_EN defined: a timeout with retry_count==MAX_RETRIES -> FAULT: fault=1, pll_rst=1,
//     sys_rst=1, ready=0; force_relock ignored; only rst exits FAULT.
//   PLL_SEQ_FAULT_EN undefined: no FAULT state; retries continue indefinitely; fault tied to 0.
// STRUCTURE
//   pll_seq_pkg: state enum {HOLD, WAIT_LOCK, STABLE, RUN, FAULT}, default parameter constants,
//     RETRY_W=8.
//   Sub-module sync_2ff (1-bit, refclk, synchronous reset to 0) for locked. The FSM and counters are
//     inline in pll_reset_sequencer.
//   Downstream outclk-domain reset synchronizers are outside this block.
// TESTING (RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2)
//   1. rst 1->0, locked rises 10 cycles later and stays high -> pll_rst falls 4 cycles after rst release;
//      sys_rst falls and ready rises 10 cycles after locked is first sampled; retry_count=0.
//   2. locked drops for 1 cycle when stable count=5 -> back to WAIT_LOCK, no RUN; relock then takes
//      a full 8 stable cycles.
//   3. locked held 0 -> after 20 WAIT_LOCK cycles pll_rst=1 for 4 cycles, retry_count=1; with
//      PLL_SEQ_FAULT_EN the 3rd timeout sets fault=1 and pll_rst stays 1; without it retries continue.
//   4. In RUN, locked falls -> lock_lost one pulse exactly 3 edges later, sys_rst=1 and pll_rst=1 on
//      the same edge; after relock sys_rst falls again.
//   5. In RUN, force_relock pulse -> sys_rst=1 next edge, lock_lost stays 0; force_relock together
//      with lock loss -> one re-sequence and one lock_lost pulse.
//   6. rst asserted mid-STABLE and in FAULT -> all outputs at reset values after one edge; normal
//      sequence on release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and constants for the PLL reset sequencer.
//   seq_state_t    : sequencer state encoding
//   DEF_*          : default values for the sequencer parameters
//   RETRY_W        : width of the retry counter output
//   sat_inc_retry  : saturating increment for the retry counter
// ---------------------------------------------------------------------------
package pll_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } seq_state_t;

   localparam int DEF_RST_HOLD_CYCLES     = 16;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_MAX_RETRIES         = 3;

   localparam int RETRY_W = 8;
   localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

   // Retry counter sticks at all-ones instead of wrapping back to zero.
   function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] value);
      return (value == RETRY_SAT) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level into the clk domain.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges behind d
// ---------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; the second gives it a full cycle to settle
   // before anything downstream looks at the value.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Brings up the system PLL: holds it in reset, waits for lock with a timeout
// and retry, debounces lock, then releases the system reset. Lock loss or a
// software request re-runs the whole sequence.
//
// Optional feature: define PLL_SEQ_FAULT_EN to add a sticky FAULT state that is
// entered when a lock timeout happens with retry_count == MAX_RETRIES. Without
// the macro, retries continue forever and fault is always 0.
//
// Ports:
//   refclk       in   free-running reference clock, only clock of the block
//   rst          in   synchronous active-high reset
//   locked       in   PLL lock indicator, asynchronous to refclk
//   force_relock in   single-cycle request to restart the sequence
//   pll_rst      out  reset to the PLL
//   sys_rst      out  system reset, released once lock is stable
//   ready        out  high only while running
//   lock_lost    out  one-cycle pulse when lock drops while running
//   retry_count  out  lock timeouts since last entry into RUN, saturating
//   fault        out  sticky sequencing failure
// ---------------------------------------------------------------------------
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               locked,
   input  logic               force_relock,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_count,
   output logic               fault
);

   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [STB_W-1:0]  STB_DONE  = STB_W'(LOCK_STABLE_CYCLES);

   // A retry limit that does not fit the retry counter can never be matched.
   localparam bit RETRY_CFG_OK = (MAX_RETRIES >= 0) && (MAX_RETRIES < (1 << RETRY_W));

   if (!RETRY_CFG_OK) begin : g_retry_cfg_out_of_range
   end

   seq_state_t        state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [STB_W-1:0]  stb_cnt;
   logic              locked_s;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (locked),
      .q   (locked_s)
   );

   // Main sequencer. Every output is a register updated alongside the state,
   // so each output changes on the same edge as the transition that implies it.
   //   HOLD      : pll_rst high for RST_HOLD_CYCLES cycles
   //   WAIT_LOCK : PLL running, wait for synced lock or time out and retry
   //   STABLE    : lock must stay high LOCK_STABLE_CYCLES samples in a row;
   //               the release edge comes one cycle after the count is reached
   //   RUN       : system out of reset until lock loss or a relock request
   //   FAULT     : only with PLL_SEQ_FAULT_EN, left only through rst
   // force_relock restarts from HOLD anywhere except FAULT; retry_count is only
   // touched by timeouts and by RUN entry.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= HOLD;
         hold_cnt    <= '0;
         tmo_cnt     <= '0;
         stb_cnt     <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         lock_lost   <= 1'b0;
         retry_count <= '0;
         fault       <= 1'b0;
      end else begin
         lock_lost <= 1'b0;
         case (state)
            HOLD: begin
               if (force_relock) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= WAIT_LOCK;
                  hold_cnt <= '0;
                  tmo_cnt  <= '0;
                  pll_rst  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            WAIT_LOCK: begin
               if (force_relock) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  tmo_cnt  <= '0;
                  pll_rst  <= 1'b1;
               end else if (locked_s) begin
                  state   <= STABLE;
                  stb_cnt <= STB_W'(1);
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt  <= '0;
                  hold_cnt <= '0;
                  pll_rst  <= 1'b1;
`ifdef PLL_SEQ_FAULT_EN
                  if (retry_count == RETRY_W'(MAX_RETRIES)) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state       <= HOLD;
                     retry_count <= sat_inc_retry(retry_count);
                  end
`else
                  state       <= HOLD;
                  retry_count <= sat_inc_retry(retry_count);
`endif
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            STABLE: begin
               if (force_relock) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  stb_cnt  <= '0;
                  pll_rst  <= 1'b1;
               end else if (!locked_s) begin
                  // A glitch restarts the debounce without costing a retry.
                  state   <= WAIT_LOCK;
                  tmo_cnt <= '0;
                  stb_cnt <= '0;
               end else if (stb_cnt == STB_DONE) begin
                  state       <= RUN;
                  stb_cnt     <= '0;
                  sys_rst     <= 1'b0;
                  ready       <= 1'b1;
                  retry_count <= '0;
               end else begin
                  stb_cnt <= stb_cnt + 1'b1;
               end
            end

            RUN: begin
               // Lock loss takes priority so a simultaneous request still pulses.
               if (!locked_s || force_relock) begin
                  state     <= HOLD;
                  hold_cnt  <= '0;
                  pll_rst   <= 1'b1;
                  sys_rst   <= 1'b1;
                  ready     <= 1'b0;
                  lock_lost <= !locked_s;
               end
            end

`ifdef PLL_SEQ_FAULT_EN
            FAULT: begin
               pll_rst <= 1'b1;
               sys_rst <= 1'b1;
               ready   <= 1'b0;
               fault   <= 1'b1;
            end
`endif

            default: begin
               state    <= HOLD;
               hold_cnt <= '0;
               tmo_cnt  <= '0;
               stb_cnt  <= '0;
               pll_rst  <= 1'b1;
               sys_rst  <= 1'b1;
               ready    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Scenario bench for pll_reset_sequencer with RST_HOLD=4, TIMEOUT=20,
// STABLE=8, MAX_RETRIES=2. Each scenario pushes the output values it expects
// at given cycles into a queue, drives its stimulus cycle by cycle, and pops
// and compares entries as their cycle comes up. Output vector layout:
// {pll_rst, sys_rst, ready, lock_lost, fault, retry_count[7:0]}.
// Expectations depend on PLL_SEQ_FAULT_EN where the fault feature matters.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   localparam int RH = 4;
   localparam int TO = 20;
   localparam int ST = 8;
   localparam int MR = 2;

   typedef struct {
      string       tag;
      int          at;
      logic [12:0] val;
   } exp_t;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       force_relock = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       lock_lost;
   logic [7:0] retry_count;
   logic       fault;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   pll_reset_sequencer #(
      .RST_HOLD_CYCLES     (RH),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (ST),
      .MAX_RETRIES         (MR)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .locked       (locked),
      .force_relock (force_relock),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .lock_lost    (lock_lost),
      .retry_count  (retry_count),
      .fault        (fault)
   );

   // Free-running 100 MHz reference clock.
   always #5 refclk = ~refclk;

   // Hard stop in case a scenario loop never completes.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: run still active at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [12:0] ev(input logic p, input logic s, input logic r,
                                      input logic l, input logic f, input int rc);
      return {p, s, r, l, f, 8'(rc)};
   endfunction

   function automatic logic [12:0] outv();
      return {pll_rst, sys_rst, ready, lock_lost, fault, retry_count};
   endfunction

   task automatic push(input string tag, input int at, input logic [12:0] v);
      exp_t e;
      e.tag = tag;
      e.at  = at;
      e.val = v;
      sb.push_back(e);
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic applyStimulus();
      @(posedge refclk);
      cyc++;
      #1;
   endtask

   // Reset values must appear after the first reset edge and hold.
   task automatic test_reset();
      int   base;
      exp_t e;
      base = cyc;
      push("reset_first_edge", base + 1, ev(1, 1, 0, 0, 0, 0));
      push("reset_held",       base + 3, ev(1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         rst = 1'b1;
         applyStimulus();
         while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            total++;
            if (outv() !== e.val) begin
               bad++;
               $display("[TB] FAIL %s: got %b want %b (cycle %0d)", e.tag, outv(), e.val, cyc);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); total++; bad++;
         $display("[TB] FAIL %s: got no sample want %b", e.tag, e.val);
      end
   endtask

   // Release reset, lock 10 cycles later; release lands 10 edges after sampling.
   task automatic test_bringup();
      int   base;
      exp_t e;
      base = cyc;
      push("hold_last",     base + 3,  ev(1, 1, 0, 0, 0, 0));
      push("pll_rst_fall",  base + 4,  ev(0, 1, 0, 0, 0, 0));
      push("wait_lock",     base + 12, ev(0, 1, 0, 0, 0, 0));
      push("pre_release",   base + 20, ev(0, 1, 0, 0, 0, 0));
      push("sys_rst_fall",  base + 21, ev(0, 0, 1, 0, 0, 0));
      for (int i = 0; i < 22; i++) begin
         if (i == 0)  rst = 1'b0;
         if (i == 10) locked = 1'b1;
         applyStimulus();
         while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            total++;
            if (outv() !== e.val) begin
               bad++;
               $display("[TB] FAIL %s: got %b want %b (cycle %0d)", e.tag, outv(), e.val, cyc);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); total++; bad++;
         $display("[TB] FAIL %s: got no sample want %b", e.tag, e.val);
      end
   endtask

   // Lock drop in RUN: pulse on the third edge, then full re-sequence.
   task automatic test_lock_loss();
      int   base;
      exp_t e;
      base = cyc;
      push("run_before_loss", base + 2,  ev(0, 0, 1, 0, 0, 0));
      push("lock_lost_pulse", base + 3,  ev(1, 1, 0, 1, 0, 0));
      push("lock_lost_clear", base + 4,  ev(1, 1, 0, 0, 0, 0));
      push("relock_wait",     base + 7,  ev(0, 1, 0, 0, 0, 0));
      push("relock_pre",      base + 18, ev(0, 1, 0, 0, 0, 0));
      push("relock_run",      base + 19, ev(0, 0, 1, 0, 0, 0));
      for (int i = 0; i < 20; i++) begin
         if (i == 0) locked = 1'b0;
         if (i == 8) locked = 1'b1;
         applyStimulus();
         while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            total++;
            if (outv() !== e.val) begin
               bad++;
               $display("[TB] FAIL %s: got %b want %b (cycle %0d)", e.tag, outv(), e.val, cyc);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); total++; bad++;
         $display("[TB] FAIL %s: got no sample want %b", e.tag, e.val);
      end
   endtask

   // Relock request alone (no pulse), then together with lock loss (one pulse).
   task automatic test_force_relock();
      int   base;
      exp_t e;
      base = cyc;
      push("force_hold",       base + 1,  ev(1, 1, 0, 0, 0, 0));
      push("force_no_pulse",   base + 2,  ev(1, 1, 0, 0, 0, 0));
      push("force_pre_run",    base + 13, ev(0, 1, 0, 0, 0, 0));
      push("force_run",        base + 14, ev(0, 0, 1, 0, 0, 0));
      push("both_pre",         base + 17, ev(0, 0, 1, 0, 0, 0));
      push("both_pulse",       base + 18, ev(1, 1, 0, 1, 0, 0));
      push("both_single_a",    base + 19, ev(1, 1, 0, 0, 0, 0));
      push("both_single_b",    base + 21, ev(1, 1, 0, 0, 0, 0));
      push("both_wait",        base + 22, ev(0, 1, 0, 0, 0, 0));
      push("both_pre_run",     base + 33, ev(0, 1, 0, 0, 0, 0));
      push("both_run",         base + 34, ev(0, 0, 1, 0, 0, 0));
      for (int i = 0; i < 35; i++) begin
         if (i == 0)  force_relock = 1'b1;
         if (i == 1)  force_relock = 1'b0;
         if (i == 15) locked = 1'b0;
         if (i == 17) force_relock = 1'b1;
         if (i == 18) force_relock = 1'b0;
         if (i == 23) locked = 1'b1;
         applyStimulus();
         while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            total++;
            if (outv() !== e.val) begin
               bad++;
               $display("[TB] FAIL %s: got %b want %b (cycle %0d)", e.tag, outv(), e.val, cyc);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); total++; bad++;
         $display("[TB] FAIL %s: got no sample want %b", e.tag, e.val);
      end
   endtask

   // One-cycle lock glitch at stable count 5 restarts the debounce.
   task automatic test_stable_glitch();
      int   base;
      exp_t e;
      base = cyc;
      push("glitch_no_early_run", base + 14, ev(0, 1, 0, 0, 0, 0));
      push("glitch_pre_run",      base + 19, ev(0, 1, 0, 0, 0, 0));
      push("glitch_run",          base + 20, ev(0, 0, 1, 0, 0, 0));
      for (int i = 0; i < 21; i++) begin
         if (i == 0) force_relock = 1'b1;
         if (i == 1) force_relock = 1'b0;
         if (i == 8) locked = 1'b0;
         if (i == 9) locked = 1'b1;
         applyStimulus();
         while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            total++;
            if (outv() !== e.val) begin
               bad++;
               $display("[TB] FAIL %s: got %b want %b (cycle %0d)", e.tag, outv(), e.val, cyc);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); total++; bad++;
         $display("[TB] FAIL %s: got no sample want %b", e.tag, e.val);
      end
   endtask

   // Lock held low: timeouts every 24 cycles; fault or saturation afterwards.
   task automatic test_timeout();
      int   base;
      int   len;
      exp_t e;
      base = cyc;
      push("to_lock_lost",   base + 3,  ev(1, 1, 0, 1, 0, 0));
      push("to_wait",        base + 7,  ev(0, 1, 0, 0, 0, 0));
      push("to_wait_last",   base + 26, ev(0, 1, 0, 0, 0, 0));
      push("to_retry1",      base + 27, ev(1, 1, 0, 0, 0, 1));
      push("to_retry1_hold", base + 30, ev(1, 1, 0, 0, 0, 1));
      push("to_retry1_wait", base + 31, ev(0, 1, 0, 0, 0, 1));
      push("to_retry2",      base + 51, ev(1, 1, 0, 0, 0, 2));
`ifdef PLL_SEQ_FAULT_EN
      push("fault_enter",    base + 75, ev(1, 1, 0, 0, 1, 2));
      push("fault_sticky",   base + 80, ev(1, 1, 0, 0, 1, 2));
      push("fault_ign_force", base + 85, ev(1, 1, 0, 0, 1, 2));
      len = 87;
`else
      push("retry3",         base + 75,   ev(1, 1, 0, 0, 0, 3));
      push("retry3_wait",    base + 79,   ev(0, 1, 0, 0, 0, 3));
      push("retry254_wait",  base + 6122, ev(0, 1, 0, 0, 0, 254));
      push("retry255",       base + 6123, ev(1, 1, 0, 0, 0, 255));
      push("retry_saturate", base + 6147, ev(1, 1, 0, 0, 0, 255));
      push("sat_pre_run",    base + 6160, ev(0, 1, 0, 0, 0, 255));
      push("run_clears_retry", base + 6161, ev(0, 0, 1, 0, 0, 0));
      len = 6163;
`endif
      for (int i = 0; i < len; i++) begin
         if (i == 0) locked = 1'b0;
`ifdef PLL_SEQ_FAULT_EN
         if (i == 81) force_relock = 1'b1;
         if (i == 82) force_relock = 1'b0;
`else
         if (i == 6150) locked = 1'b1;
`endif
         applyStimulus();
         while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            total++;
            if (outv() !== e.val) begin
               bad++;
               $display("[TB] FAIL %s: got %b want %b (cycle %0d)", e.tag, outv(), e.val, cyc);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); total++; bad++;
         $display("[TB] FAIL %s: got no sample want %b", e.tag, e.val);
      end
   endtask

   // rst from the current state (FAULT when enabled), then again mid-STABLE.
   task automatic test_reset_mid();
      int   base;
      exp_t e;
      base = cyc;
      push("rst_any_state",  base + 1,  ev(1, 1, 0, 0, 0, 0));
      push("rst_stable_pre", base + 9,  ev(0, 1, 0, 0, 0, 0));
      push("rst_mid_stable", base + 10, ev(1, 1, 0, 0, 0, 0));
      push("rst_rel_hold",   base + 13, ev(1, 1, 0, 0, 0, 0));
      push("rst_rel_wait",   base + 14, ev(0, 1, 0, 0, 0, 0));
      push("rst_rel_pre",    base + 22, ev(0, 1, 0, 0, 0, 0));
      push("rst_rel_run",    base + 23, ev(0, 0, 1, 0, 0, 0));
      for (int i = 0; i < 24; i++) begin
         if (i == 0)  rst = 1'b1;
         if (i == 1)  begin rst = 1'b0; locked = 1'b1; end
         if (i == 9)  rst = 1'b1;
         if (i == 10) rst = 1'b0;
         applyStimulus();
         while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            total++;
            if (outv() !== e.val) begin
               bad++;
               $display("[TB] FAIL %s: got %b want %b (cycle %0d)", e.tag, outv(), e.val, cyc);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front(); total++; bad++;
         $display("[TB] FAIL %s: got no sample want %b", e.tag, e.val);
      end
   endtask

   // Scenarios run back to back; each one starts from where the previous left off.
   initial begin
      $display("[TB] starting pll_reset_sequencer scenarios");
      test_reset();
      test_bringup();
      test_lock_loss();
      test_force_relock();
      test_stable_glitch();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
